gnn_mlp_4x4x2: RTL and testbench

- Fixed-topology two-layer inference block: 4 signed 5-bit inputs, 4 hidden neurons (nodes 4..7, ReLU), 2 linear output neurons (nodes 8, 9).
- All weights arrive in parallel with the inputs.
- Two-stage pipeline with a one-cycle input strobe and one-cycle result strobes.
- Sits as the top-level compute core of the MS1 accelerator.

---
 rtl/gnn_mlp_4x4x2.sv | 169 ++++++++++++++++
 tb/tb_gnn_mlp_4x4x2.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gnn_mlp_4x4x2.sv
// Two-layer 4-4-2 inference core: ReLU hidden layer, linear outputs, two-stage pipeline.
// Define GNN_HIDDEN_DBG_EN to expose the registered hidden activations on h4_dbg..h7_dbg.
module gnn_mlp_4x4x2 #(
  parameter int IN_W  = 5,
  parameter int HID_W = 11,
  parameter int OUT_W = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_ready,
  input  logic signed [IN_W-1:0]  x0,
  input  logic signed [IN_W-1:0]  x1,
  input  logic signed [IN_W-1:0]  x2,
  input  logic signed [IN_W-1:0]  x3,
  input  logic signed [IN_W-1:0]  w04,
  input  logic signed [IN_W-1:0]  w14,
  input  logic signed [IN_W-1:0]  w24,
  input  logic signed [IN_W-1:0]  w34,
  input  logic signed [IN_W-1:0]  w05,
  input  logic signed [IN_W-1:0]  w15,
  input  logic signed [IN_W-1:0]  w25,
  input  logic signed [IN_W-1:0]  w35,
  input  logic signed [IN_W-1:0]  w06,
  input  logic signed [IN_W-1:0]  w16,
  input  logic signed [IN_W-1:0]  w26,
  input  logic signed [IN_W-1:0]  w36,
  input  logic signed [IN_W-1:0]  w07,
  input  logic signed [IN_W-1:0]  w17,
  input  logic signed [IN_W-1:0]  w27,
  input  logic signed [IN_W-1:0]  w37,
  input  logic signed [IN_W-1:0]  w48,
  input  logic signed [IN_W-1:0]  w58,
  input  logic signed [IN_W-1:0]  w68,
  input  logic signed [IN_W-1:0]  w78,
  input  logic signed [IN_W-1:0]  w49,
  input  logic signed [IN_W-1:0]  w59,
  input  logic signed [IN_W-1:0]  w69,
  input  logic signed [IN_W-1:0]  w79,
  output logic signed [OUT_W-1:0] out0,
  output logic signed [OUT_W-1:0] out1,
  output logic                    out0_ready,
  output logic                    out1_ready
`ifdef GNN_HIDDEN_DBG_EN
  ,
  output logic [HID_W-1:0]        h4_dbg,
  output logic [HID_W-1:0]        h5_dbg,
  output logic [HID_W-1:0]        h6_dbg,
  output logic [HID_W-1:0]        h7_dbg
`endif
);

  // Hidden sums span -960..1024, which needs two bits beyond the product width.
  localparam int SUM1_W = 2 * IN_W + 2;

  logic signed [IN_W-1:0]   x_p0  [4];
  logic signed [IN_W-1:0]   w1_p0 [4][4];
  logic signed [IN_W-1:0]   w2_p0 [4][2];
  logic signed [SUM1_W-1:0] sum_p0 [4];

  logic [HID_W-1:0]         h_p1  [4];
  logic signed [IN_W-1:0]   w2_p1 [4][2];
  logic                     vld_p1;
  logic signed [OUT_W-1:0]  acc_p1 [2];

  logic                     vld_p2;

  function automatic logic [HID_W-1:0] relu(input logic signed [SUM1_W-1:0] s);
    if (s[SUM1_W-1]) return '0;
    return s[HID_W-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] hid_ext(input logic [HID_W-1:0] h);
    return signed'(OUT_W'(h));
  endfunction

  assign x_p0[0] = x0;
  assign x_p0[1] = x1;
  assign x_p0[2] = x2;
  assign x_p0[3] = x3;

  assign w1_p0[0][0] = w04;
  assign w1_p0[1][0] = w14;
  assign w1_p0[2][0] = w24;
  assign w1_p0[3][0] = w34;
  assign w1_p0[0][1] = w05;
  assign w1_p0[1][1] = w15;
  assign w1_p0[2][1] = w25;
  assign w1_p0[3][1] = w35;
  assign w1_p0[0][2] = w06;
  assign w1_p0[1][2] = w16;
  assign w1_p0[2][2] = w26;
  assign w1_p0[3][2] = w36;
  assign w1_p0[0][3] = w07;
  assign w1_p0[1][3] = w17;
  assign w1_p0[2][3] = w27;
  assign w1_p0[3][3] = w37;

  assign w2_p0[0][0] = w48;
  assign w2_p0[1][0] = w58;
  assign w2_p0[2][0] = w68;
  assign w2_p0[3][0] = w78;
  assign w2_p0[0][1] = w49;
  assign w2_p0[1][1] = w59;
  assign w2_p0[2][1] = w69;
  assign w2_p0[3][1] = w79;

  // Stage 1: hidden dot products, ReLU, capture of output-layer weights
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sum_p0[k] = '0;
      for (int i = 0; i < 4; i++)
        sum_p0[k] = sum_p0[k] + SUM1_W'(x_p0[i]) * SUM1_W'(w1_p0[i][k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        h_p1[k]     <= '0;
        w2_p1[k][0] <= '0;
        w2_p1[k][1] <= '0;
      end
    end else begin
      vld_p1 <= in_ready;
      if (in_ready) begin
        for (int k = 0; k < 4; k++) begin
          h_p1[k]     <= relu(sum_p0[k]);
          w2_p1[k][0] <= w2_p0[k][0];
          w2_p1[k][1] <= w2_p0[k][1];
        end
      end
    end
  end

  // Stage 2: linear output layer; the full range fits OUT_W exactly, so no saturation
  always_comb begin
    for (int o = 0; o < 2; o++) begin
      acc_p1[o] = '0;
      for (int j = 0; j < 4; j++)
        acc_p1[o] = acc_p1[o] + hid_ext(h_p1[j]) * OUT_W'(w2_p1[j][o]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      out0   <= '0;
      out1   <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        out0 <= acc_p1[0];
        out1 <= acc_p1[1];
      end
    end
  end

  assign out0_ready = vld_p2;
  assign out1_ready = vld_p2;

`ifdef GNN_HIDDEN_DBG_EN
  assign h4_dbg = h_p1[0];
  assign h5_dbg = h_p1[1];
  assign h6_dbg = h_p1[2];
  assign h7_dbg = h_p1[3];
`endif

endmodule

// File: tb/tb_gnn_mlp_4x4x2.sv
// Directed bench for gnn_mlp_4x4x2: vector table plus back-to-back, hold and mid-flight reset sequences.
module tb_gnn_mlp_4x4x2;

  logic clk;
  logic rst_n;
  logic in_ready;
  logic signed [4:0] x0, x1, x2, x3;
  logic signed [4:0] w04, w14, w24, w34, w05, w15, w25, w35;
  logic signed [4:0] w06, w16, w26, w36, w07, w17, w27, w37;
  logic signed [4:0] w48, w58, w68, w78, w49, w59, w69, w79;
  logic signed [16:0] out0, out1;
  logic out0_ready, out1_ready;

  int checks;
  int failures;

  typedef struct packed {
    logic [3:0][4:0]  x;
    logic [15:0][4:0] w1;
    logic [7:0][4:0]  w2;
    int               e0;
    int               e1;
  } vec_t;

  vec_t tbl [4];

  gnn_mlp_4x4x2 dut (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .w04(w04), .w14(w14), .w24(w24), .w34(w34),
    .w05(w05), .w15(w15), .w25(w25), .w35(w35),
    .w06(w06), .w16(w16), .w26(w26), .w36(w36),
    .w07(w07), .w17(w17), .w27(w27), .w37(w37),
    .w48(w48), .w58(w58), .w68(w68), .w78(w78),
    .w49(w49), .w59(w59), .w69(w69), .w79(w79),
    .out0(out0), .out1(out1), .out0_ready(out0_ready), .out1_ready(out1_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0][4:0] p4(input int a, input int b, input int c, input int d);
    logic [3:0][4:0] r;
    r[0] = a[4:0];
    r[1] = b[4:0];
    r[2] = c[4:0];
    r[3] = d[4:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    x0 = v.x[0];   x1 = v.x[1];   x2 = v.x[2];   x3 = v.x[3];
    w04 = v.w1[0];  w14 = v.w1[1];  w24 = v.w1[2];  w34 = v.w1[3];
    w05 = v.w1[4];  w15 = v.w1[5];  w25 = v.w1[6];  w35 = v.w1[7];
    w06 = v.w1[8];  w16 = v.w1[9];  w26 = v.w1[10]; w36 = v.w1[11];
    w07 = v.w1[12]; w17 = v.w1[13]; w27 = v.w1[14]; w37 = v.w1[15];
    w48 = v.w2[0];  w58 = v.w2[1];  w68 = v.w2[2];  w78 = v.w2[3];
    w49 = v.w2[4];  w59 = v.w2[5];  w69 = v.w2[6];  w79 = v.w2[7];
  endtask

  // Inputs are don't-care once sampled; garbage here exposes any late sampling.
  task automatic scramble();
    vec_t v;
    v.x  = $urandom;
    v.w1 = {$urandom, $urandom, $urandom};
    v.w2 = {$urandom, $urandom};
    v.e0 = 0;
    v.e1 = 0;
    drive(v);
  endtask

  task automatic chk_rdy(input string name, input logic exp);
    chk({name, "_rdy0"}, 32'(out0_ready), 32'(exp));
    chk({name, "_rdy1"}, 32'(out1_ready), 32'(exp));
  endtask

  task automatic chk_out(input string name, input int e0, input int e1);
    chk({name, "_out0"}, 32'(out0), e0);
    chk({name, "_out1"}, 32'(out1), e1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Mixed signs: h5=-36 and h6=-21 are clipped by ReLU
    tbl[0].x  = p4(4, 2, 4, 1);
    tbl[0].w1 = {p4(9, -10, 15, -10), p4(3, 6, -15, 15), p4(-9, 1, -4, 14), p4(3, 2, 13, -6)};
    tbl[0].w2 = {p4(-12, -15, -15, 6), p4(0, -1, 3, -11)};
    tbl[0].e0 = -726;
    tbl[0].e1 = -348;
    // All-positive path
    tbl[1].x  = p4(4, 2, 4, 1);
    tbl[1].w1 = {p4(9, 0, 15, 0), p4(3, 6, 0, 15), p4(0, 0, 0, 14), p4(3, 2, 13, 0)};
    tbl[1].w2 = {p4(12, 0, 0, 6), p4(0, 0, 3, 11)};
    tbl[1].e0 = 1173;
    tbl[1].e1 = 1392;
    // Negative extreme: h=1024 each, out=4*1024*(-16)
    tbl[2].x  = p4(-16, -16, -16, -16);
    tbl[2].w1 = {4{p4(-16, -16, -16, -16)}};
    tbl[2].w2 = {2{p4(-16, -16, -16, -16)}};
    tbl[2].e0 = -65536;
    tbl[2].e1 = -65536;
    // Positive extreme: h=900 each, out=4*900*15
    tbl[3].x  = p4(15, 15, 15, 15);
    tbl[3].w1 = {4{p4(15, 15, 15, 15)}};
    tbl[3].w2 = {2{p4(15, 15, 15, 15)}};
    tbl[3].e0 = 54000;
    tbl[3].e1 = 54000;

    rst_n    = 1'b0;
    in_ready = 1'b0;
    drive(tbl[0]);
    repeat (2) @(negedge clk);
    chk_rdy("reset", 1'b0);
    chk_out("reset", 0, 0);
    rst_n = 1'b1;

    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      drive(tbl[n]);
      in_ready = 1'b1;
      @(negedge clk);
      chk_rdy($sformatf("vec%0d_early", n), 1'b0);
      in_ready = 1'b0;
      scramble();
      @(negedge clk);
      chk_rdy($sformatf("vec%0d", n), 1'b1);
      chk_out($sformatf("vec%0d", n), tbl[n].e0, tbl[n].e1);
      @(negedge clk);
      chk_rdy($sformatf("vec%0d_after", n), 1'b0);
    end

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_rdy($sformatf("hold%0d", c), 1'b0);
      chk_out($sformatf("hold%0d", c), 54000, 54000);
    end

    @(negedge clk);
    drive(tbl[0]);
    in_ready = 1'b1;
    @(negedge clk);
    chk_rdy("b2b_early", 1'b0);
    drive(tbl[1]);
    @(negedge clk);
    in_ready = 1'b0;
    scramble();
    chk_rdy("b2b_first", 1'b1);
    chk_out("b2b_first", -726, -348);
    @(negedge clk);
    chk_rdy("b2b_second", 1'b1);
    chk_out("b2b_second", 1173, 1392);
    @(negedge clk);
    chk_rdy("b2b_after", 1'b0);
    chk_out("b2b_after", 1173, 1392);

    // Reset lands between the accepting edge and the result edge
    @(negedge clk);
    drive(tbl[2]);
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk_rdy("rst_async", 1'b0);
    chk_out("rst_async", 0, 0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_rdy("rst_flush", 1'b0);
    chk_out("rst_flush", 0, 0);
    @(negedge clk);
    chk_rdy("rst_flush2", 1'b0);
    chk_out("rst_flush2", 0, 0);

    @(negedge clk);
    drive(tbl[0]);
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    scramble();
    @(negedge clk);
    chk_rdy("recover", 1'b1);
    chk_out("recover", -726, -348);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
